// File: rtl/neuron_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_mac_sequencer
//  Description : Time-multiplexed single-neuron controller. It accepts
//                N_INPUTS pixel/weight pairs over a valid/ready handshake and
//                runs them through one shared multiply-accumulate path. It
//                then adds the bias, applies ReLU and holds the result on a
//                valid/ready output until the consumer takes it.
//  Ports       : clk, rst_n (async assert, active low)
//                start, bias                  - begin evaluation, latch bias
//                in_valid/in_ready, pixel,    - pair stream
//                weight
//                out_valid/out_ready,         - result handshake
//                activation
//                busy, pair_cnt               - status
//  Config      : NEURON_SAT_EN - saturating accumulate and bias add
//                (default build wraps modulo 2^ACC_W)
//  Revision    : 1.0 - initial release
// ============================================================================
module neuron_mac_sequencer #(
    parameter int DATA_W   = 20,
    parameter int ACC_W    = 40,
    parameter int N_INPUTS = 16,
    parameter int CNT_W    = $clog2(N_INPUTS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] pixel,
    input  logic [DATA_W-1:0] weight,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  activation,
    output logic              busy,
    output logic [CNT_W-1:0]  pair_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_BIAS   = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    // Counter value held while the final pair is being accepted
    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(N_INPUTS - 1);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic        [ACC_W-1:0]   r_acc;
    logic signed [DATA_W-1:0]  r_bias_q;
    logic        [ACC_W-1:0]   r_activation;
    logic        [CNT_W-1:0]   r_pair_cnt;

    logic signed [2*DATA_W-1:0] w_prod;
    logic        [ACC_W-1:0]    w_prod_ext;
    logic        [ACC_W-1:0]    w_bias_ext;
    logic        [ACC_W-1:0]    w_sum_mac;
    logic        [ACC_W-1:0]    w_sum_bias;
    logic                       w_accept;

    // Two-operand add used for every accumulator update. With saturation
    // enabled, overflow is seen as equal operand signs giving a result of
    // the opposite sign; the result then clamps toward the operand sign.
    function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
        logic [ACC_W-1:0] s;
        s = a + b;
`ifdef NEURON_SAT_EN
        if ((a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1])) begin
            s = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                           : {1'b0, {(ACC_W-1){1'b1}}};
        end
`endif
        return s;
    endfunction

    // Full-precision signed product: both operands are sign-extended to
    // 2*DATA_W before the multiply so no bits are lost.
    assign w_prod     = (2*DATA_W)'($signed(pixel)) * (2*DATA_W)'($signed(weight));
    assign w_prod_ext = ACC_W'(w_prod);
    assign w_bias_ext = ACC_W'(r_bias_q);
    assign w_sum_mac  = acc_add(r_acc, w_prod_ext);
    assign w_sum_bias = acc_add(r_acc, w_bias_ext);
    assign w_accept   = (r_state == S_ACCUM) && in_valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                in_ready = 1'b1;
                if (w_accept && (r_pair_cnt == c_LAST_CNT)) begin
                    w_state_nxt = S_BIAS;
                end
            end
            S_BIAS: begin
                w_state_nxt = S_OUTPUT;
            end
            S_OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath. The activation is computed from the bias sum during BIAS so
    // that it is already registered on the first OUTPUT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc        <= '0;
            r_bias_q     <= '0;
            r_activation <= '0;
            r_pair_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_bias_q   <= $signed(bias);
                        r_acc      <= '0;
                        r_pair_cnt <= '0;
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        r_acc      <= w_sum_mac;
                        r_pair_cnt <= r_pair_cnt + CNT_W'(1);
                    end
                end
                S_BIAS: begin
                    r_acc        <= w_sum_bias;
                    r_activation <= w_sum_bias[ACC_W-1] ? '0 : w_sum_bias;
                end
                default: begin
                end
            endcase
        end
    end

    assign activation = r_activation;
    assign pair_cnt   = r_pair_cnt;

endmodule
`default_nettype wire
